// File: rtl/irq_controller_if.sv
// Bundles the interrupt controller's request, mask, enable and CPU-facing signals.
//   master: request sources, mask writer, RAM enable and CPU acknowledge (drives inputs)
//   slave : the interrupt controller itself (drives irq/vector/status)
interface irq_controller_if #(
  parameter int unsigned NSRC = 4
);
  logic [NSRC-1:0] srcIn;       // asynchronous request levels
  logic            maskWE;      // one-cycle mask load strobe
  logic [NSRC-1:0] maskData;    // new mask, 1 = source enabled
  logic            intEn;       // global enable from RAM
  logic            turnOffIRQ;  // CPU acknowledge, clk2 domain
  logic            irq;         // request to CPU
  logic [31:0]     intAddr;     // vector of the requested source
  logic [2:0]      activeSrc;   // index of the winning source
  logic [NSRC-1:0] pending;     // pending request register
  logic [NSRC-1:0] mask;        // current mask register

  modport master (
    output srcIn, maskWE, maskData, intEn, turnOffIRQ,
    input  irq, intAddr, activeSrc, pending, mask
  );

  modport slave (
    input  srcIn, maskWE, maskData, intEn, turnOffIRQ,
    output irq, intAddr, activeSrc, pending, mask
  );
endinterface

// File: rtl/irq_controller.sv
// Multi-source interrupt controller (fastClk domain).
// Edge-detects NSRC asynchronous request lines into a pending register, masks them,
// picks the lowest-index eligible source and presents irq/intAddr to the CPU. The
// request retires on a synchronised rising edge of the clk2-domain turnOffIRQ.
// Ports:
//   fastClk : clock, all flops on rising edge
//   rst     : synchronous active-high reset
//   bus     : irq_controller_if.slave (srcIn, maskWE, maskData, intEn, turnOffIRQ in;
//             irq, intAddr, activeSrc, pending, mask out)
module irq_controller #(
  parameter int unsigned NSRC       = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic             fastClk,
  input  logic             rst,
  irq_controller_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] RETIRE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NSRC-1:0] src_s1_q, src_s2_q, src_s3_q;
  logic            ack_s1_q, ack_s2_q, ack_s3_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic            irq_q, irq_d;
  logic [31:0]     addr_q, addr_d;
  logic [2:0]      act_q, act_d;

  logic [NSRC-1:0] src_edge_c;
  logic [NSRC-1:0] elig_c;
  logic [NSRC-1:0] pend_clr_c;
  logic            ack_edge_c;
  logic            ack_lvl_c;
  logic [2:0]      winner_c;

  assign src_edge_c = src_s2_q & ~src_s3_q;
  assign ack_edge_c = ack_s2_q & ~ack_s3_q;
  assign ack_lvl_c  = ack_s2_q;
  assign elig_c     = pend_q & mask_q;

  // Priority encoder: lowest set index wins (scan downward so the last hit is the lowest).
  always_comb begin
    winner_c = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (elig_c[i]) winner_c = 3'(i);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    irq_d      = irq_q;
    addr_d     = addr_q;
    act_d      = act_q;
    pend_clr_c = '0;
    mask_d     = bus.maskWE ? bus.maskData : mask_q;

    case (state_q)
      IDLE: begin
        irq_d = 1'b0;
        if (bus.intEn && (|elig_c)) begin
          act_d   = winner_c;
          addr_d  = VEC_BASE + 32'(winner_c) * VEC_STRIDE;
          irq_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // Winner stays frozen here; masking or higher-priority arrivals do not preempt.
        if (ack_edge_c) begin
          for (int unsigned i = 0; i < NSRC; i++) begin
            if (act_q == 3'(i)) pend_clr_c[i] = 1'b1;
          end
          irq_d   = 1'b0;
          state_d = RETIRE;
        end else if (!bus.intEn) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end
      end
      RETIRE: begin
        // Hold until the acknowledge level drops so a long ack retires only one request.
        irq_d = 1'b0;
        if (!ack_lvl_c) state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    // A fresh edge in the same cycle as its clear keeps the bit set.
    pend_d = (pend_q & ~pend_clr_c) | src_edge_c;
  end

  // State, synchronisers and output registers.
  always_ff @(posedge fastClk) begin
    if (rst) begin
      state_q  <= IDLE;
      src_s1_q <= '0;
      src_s2_q <= '0;
      src_s3_q <= '0;
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
      ack_s3_q <= 1'b0;
      pend_q   <= '0;
      mask_q   <= '1;
      irq_q    <= 1'b0;
      addr_q   <= VEC_BASE;
      act_q    <= '0;
    end else begin
      state_q  <= state_d;
      src_s1_q <= bus.srcIn;
      src_s2_q <= src_s1_q;
      src_s3_q <= src_s2_q;
      ack_s1_q <= bus.turnOffIRQ;
      ack_s2_q <= ack_s1_q;
      ack_s3_q <= ack_s2_q;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      irq_q    <= irq_d;
      addr_q   <= addr_d;
      act_q    <= act_d;
    end
  end

  assign bus.irq       = irq_q;
  assign bus.intAddr   = addr_q;
  assign bus.activeSrc = act_q;
  assign bus.pending   = pend_q;
  assign bus.mask      = mask_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized
// request/mask/ack rounds, with a vector scoreboard popped on every irq rise.
module tb_irq_controller;

  localparam int unsigned NSRC = 4;

  logic fastClk = 1'b0;
  logic rst;

  irq_controller_if #(.NSRC(NSRC)) bus ();

  irq_controller #(
    .NSRC       (NSRC),
    .VEC_BASE   (32'h0000_0100),
    .VEC_STRIDE (32'h0000_0010)
  ) dut (
    .fastClk (fastClk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 fastClk = ~fastClk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [34:0] exp_q[$];
  logic        irq_prev = 1'b0;
  logic [3:0]  model_pend;
  logic [3:0]  model_mask;

  function automatic logic [31:0] vec(input int s);
    return 32'h0000_0100 + 32'(s) * 32'h0000_0010;
  endfunction

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge fastClk);
  endtask

  task automatic expect_vec(input int s);
    exp_q.push_back({3'(s), vec(s)});
  endtask

  task automatic wait_irq(input logic level, input int budget, input string name);
    int k = 0;
    while (bus.irq !== level && k < budget) begin
      tick();
      k++;
    end
    chk(name, 64'(bus.irq), 64'(level));
  endtask

  task automatic pulse_src(input logic [3:0] s);
    bus.srcIn = s;
    tick(2);
    bus.srcIn = '0;
  endtask

  task automatic ack_and_clear();
    bus.turnOffIRQ = 1'b1;
    tick(3);
    chk("ack_irq_low", 64'(bus.irq), 64'd0);
    bus.turnOffIRQ = 1'b0;
    tick(4);
  endtask

  // Scoreboard monitor: every irq rise must match the oldest expected vector.
  always @(negedge fastClk) begin
    logic [34:0] e;
    if (bus.irq === 1'b1 && irq_prev === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_irq: actual src %0d addr %h required no request",
                 bus.activeSrc, bus.intAddr);
      end else begin
        e = exp_q.pop_front();
        chk("sb_vector", 64'({bus.activeSrc, bus.intAddr}), 64'(e));
      end
    end
    irq_prev = bus.irq;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int len;
    logic [3:0] m;
    logic [3:0] s;

    rst            = 1'b1;
    bus.srcIn      = '0;
    bus.maskWE     = 1'b0;
    bus.maskData   = '0;
    bus.intEn      = 1'b0;
    bus.turnOffIRQ = 1'b0;
    tick(3);
    rst = 1'b0;

    // Reset values
    chk("rst_irq", 64'(bus.irq), 64'd0);
    chk("rst_addr", 64'(bus.intAddr), 64'h100);
    chk("rst_act", 64'(bus.activeSrc), 64'd0);
    chk("rst_pend", 64'(bus.pending), 64'd0);
    chk("rst_mask", 64'(bus.mask), 64'hf);

    // Single source latency: pending after 3 cycles, irq one cycle later
    bus.intEn = 1'b1;
    expect_vec(2);
    pulse_src(4'b0100);
    tick(1);
    chk("t1_pend", 64'(bus.pending), 64'h4);
    chk("t1_irq_early", 64'(bus.irq), 64'd0);
    tick(1);
    chk("t1_irq", 64'(bus.irq), 64'd1);
    chk("t1_addr", 64'(bus.intAddr), 64'h120);
    chk("t1_act", 64'(bus.activeSrc), 64'd2);
    ack_and_clear();
    chk("t1_pend_clr", 64'(bus.pending), 64'd0);

    // Priority plus long acknowledge retiring exactly one request
    bus.intEn = 1'b0;
    pulse_src(4'b1010);
    tick(1);
    chk("t2_pend", 64'(bus.pending), 64'ha);
    expect_vec(1);
    bus.intEn = 1'b1;
    tick(1);
    chk("t2_irq", 64'(bus.irq), 64'd1);
    chk("t2_addr", 64'(bus.intAddr), 64'h110);
    bus.turnOffIRQ = 1'b1;
    tick(3);
    chk("t2_pend_one", 64'(bus.pending), 64'h8);
    chk("t2_irq_off", 64'(bus.irq), 64'd0);
    tick(17);
    chk("t2_pend_hold", 64'(bus.pending), 64'h8);
    chk("t2_irq_hold", 64'(bus.irq), 64'd0);
    expect_vec(3);
    bus.turnOffIRQ = 1'b0;
    tick(3);
    chk("t2_gap", 64'(bus.irq), 64'd0);
    tick(1);
    chk("t2_irq3", 64'(bus.irq), 64'd1);
    chk("t2_addr3", 64'(bus.intAddr), 64'h130);
    ack_and_clear();
    chk("t2_pend_clr", 64'(bus.pending), 64'd0);

    // Masked source stays silent until the mask is reopened
    bus.maskWE   = 1'b1;
    bus.maskData = 4'b1110;
    tick(1);
    bus.maskWE = 1'b0;
    chk("t3_mask", 64'(bus.mask), 64'he);
    pulse_src(4'b0001);
    tick(1);
    chk("t3_pend", 64'(bus.pending), 64'h1);
    tick(3);
    chk("t3_irq_masked", 64'(bus.irq), 64'd0);
    expect_vec(0);
    bus.maskWE   = 1'b1;
    bus.maskData = 4'b1111;
    tick(1);
    bus.maskWE = 1'b0;
    chk("t3_irq_1cyc", 64'(bus.irq), 64'd0);
    tick(1);
    chk("t3_irq_2cyc", 64'(bus.irq), 64'd1);

    // intEn withdraw and re-request
    bus.intEn = 1'b0;
    tick(1);
    chk("t4_irq_drop", 64'(bus.irq), 64'd0);
    chk("t4_pend_keep", 64'(bus.pending), 64'h1);
    expect_vec(0);
    bus.intEn = 1'b1;
    tick(1);
    chk("t4_irq_again", 64'(bus.irq), 64'd1);
    chk("t4_addr", 64'(bus.intAddr), 64'h100);
    ack_and_clear();

    // New edge coinciding with the ack-clear of the same source
    expect_vec(1);
    pulse_src(4'b0010);
    tick(2);
    chk("t5_irq", 64'(bus.irq), 64'd1);
    bus.turnOffIRQ = 1'b1;
    bus.srcIn      = 4'b0010;
    tick(3);
    chk("t5_pend_set_wins", 64'(bus.pending), 64'h2);
    chk("t5_irq_off", 64'(bus.irq), 64'd0);
    expect_vec(1);
    bus.srcIn      = '0;
    bus.turnOffIRQ = 1'b0;
    tick(3);
    chk("t5_gap", 64'(bus.irq), 64'd0);
    tick(1);
    chk("t5_rereq", 64'(bus.irq), 64'd1);
    ack_and_clear();
    chk("t5_pend_clr", 64'(bus.pending), 64'd0);

    // Randomized rounds against the set-based reference model
    bus.intEn  = 1'b0;
    model_pend = 4'b0000;
    model_mask = 4'b1111;
    for (int it = 0; it < 20; it++) begin
      m = 4'($urandom_range(0, 15));
      bus.maskWE   = 1'b1;
      bus.maskData = m;
      tick(1);
      bus.maskWE = 1'b0;
      model_mask = m;
      chk("rnd_mask", 64'(bus.mask), 64'(model_mask));
      s = 4'($urandom_range(1, 15));
      pulse_src(s);
      tick(2);
      model_pend = model_pend | s;
      chk("rnd_pend", 64'(bus.pending), 64'(model_pend));
      w = lowest(model_pend & model_mask);
      if (w >= 0) begin
        expect_vec(w);
        bus.intEn = 1'b1;
        while (w >= 0) begin
          wait_irq(1'b1, 10, "rnd_irq_rise");
          len = $urandom_range(1, 20);
          bus.turnOffIRQ = 1'b1;
          tick(len);
          wait_irq(1'b0, 10, "rnd_irq_drop");
          model_pend[w] = 1'b0;
          chk("rnd_pend_ack", 64'(bus.pending), 64'(model_pend));
          w = lowest(model_pend & model_mask);
          if (w >= 0) expect_vec(w);
          bus.turnOffIRQ = 1'b0;
          tick(3);
        end
        bus.intEn = 1'b0;
        tick(1);
      end else begin
        bus.intEn = 1'b1;
        tick(6);
        chk("rnd_no_irq", 64'(bus.irq), 64'd0);
        bus.intEn = 1'b0;
      end
    end

    // Reset while requesting
    bus.maskWE   = 1'b1;
    bus.maskData = 4'b1011;
    tick(1);
    bus.maskWE = 1'b0;
    model_mask = 4'b1011;
    pulse_src(4'b1000);
    tick(2);
    model_pend = model_pend | 4'b1000;
    expect_vec(lowest(model_pend & model_mask));
    bus.intEn = 1'b1;
    wait_irq(1'b1, 10, "t7_irq_rise");
    rst = 1'b1;
    tick(1);
    chk("t7_irq", 64'(bus.irq), 64'd0);
    chk("t7_pend", 64'(bus.pending), 64'd0);
    chk("t7_mask", 64'(bus.mask), 64'hf);
    chk("t7_addr", 64'(bus.intAddr), 64'h100);
    chk("t7_act", 64'(bus.activeSrc), 64'd0);
    rst       = 1'b0;
    bus.intEn = 1'b0;
    tick(5);
    chk("t7_quiet", 64'(bus.irq), 64'd0);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
